// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared datapath width, ALU op codes and sign helper for the divider
package div_unit_pkg;
  localparam int W = 32;
  localparam logic [3:0] ALU_ADD          = 4'd0;
  localparam logic [3:0] ALU_SUB          = 4'd1;
  localparam logic [3:0] ALU_AND          = 4'd2;
  localparam logic [3:0] ALU_OR           = 4'd3;
  localparam logic [3:0] ALU_SIGNED_DIV   = 4'd8;
  localparam logic [3:0] ALU_UNSIGNED_DIV = 4'd9;
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the divider
interface div_unit_if;
  import div_unit_pkg::*;
  logic           start;
  logic           signed_div;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           annul;
  logic           busy;
  logic           valid;
  logic [2*W-1:0] result;
  modport master(output start, signed_div, a, b, annul, input busy, valid, result);
  modport slave(input start, signed_div, a, b, annul, output busy, valid, result);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step on an already shifted partial remainder
module div_step
  import div_unit_pkg::*;
(
  input  logic [W:0]   rem_in,
  input  logic [W:0]   dvs,
  output logic [W-1:0] rem_out,
  output logic         q
);
  assign q       = rem_in >= dvs;
  assign rem_out = q ? rem_in[W-1:0] - dvs[W-1:0] : rem_in[W-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider for DIV/DIVU producing {remainder, quotient}
module div_unit
  import div_unit_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t         state, state_n;
  logic [4:0]     cnt;
  logic [W-1:0]   rem, quo, dvs, rem_n, quo_n;
  logic           neg_q, neg_r, q_bit, accept, last, div0, busy_q, valid_q;
  logic [2*W-1:0] result_q;
  div_step u_step (
    .rem_in ({rem, quo[W-1]}),
    .dvs    ({1'b0, dvs}),
    .rem_out(rem_n),
    .q      (q_bit)
  );
  assign quo_n      = {quo[W-2:0], q_bit};
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
  // next state: annul beats everything, start is only taken outside BUSY
  always_comb begin
    div0    = bus.b == '0;
    accept  = bus.start && !bus.annul && state != BUSY;
    last    = state == BUSY && cnt == 5'd31;
    state_n = bus.annul ? IDLE : accept ? (div0 ? DONE : BUSY) : last ? DONE : state == BUSY ? BUSY : IDLE;
  end
  // state, operand capture, iteration and sign-corrected result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state   <= state_n;
      busy_q  <= state_n == BUSY;
      valid_q <= !bus.annul && (last || (accept && div0));
      if (bus.annul) result_q <= '0;
      else if (accept && div0) result_q <= {bus.a, {W{1'b1}}};
      else if (accept) begin
        rem   <= '0;
        quo   <= cond_neg(bus.a, bus.signed_div && bus.a[W-1]);
        dvs   <= cond_neg(bus.b, bus.signed_div && bus.b[W-1]);
        neg_q <= bus.signed_div && (bus.a[W-1] ^ bus.b[W-1]);
        neg_r <= bus.signed_div && bus.a[W-1];
        cnt   <= '0;
      end else if (state == BUSY) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 5'd1;
        if (last) result_q <= {cond_neg(rem_n, neg_r), cond_neg(quo_n, neg_q)};
      end
    end
  end
endmodule
